pid_core_mc: RTL and testbench
==============================

Name: pid_core_mc

Overview:
- Next-generation fixed-point PID (2nd-order IIR) controller for the fan-control loop.
- Serves CH_COUNT independent channels through one time-multiplexed multiplier.
- Adds per-request channel select, runtime output clamp limits, a saturation flag, a history clear, and a busy/done handshake.
- Sits between the ADC sampling/strobe logic and the PWM generator.

Parameters:
- ADC_BITWIDTH, 8, width of unsigned ADC and setpoint values.
- REG_BITWIDTH, 8, width of signed coefficients.
- FRAC_BITWIDTH, 4, fractional bits applied to error and feedback terms.
- CH_COUNT, 2, number of channels (≥1); CH_W = max(1, clog2(CH_COUNT)).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request strobe; accepted only in IDLE.
- ch_i  in  CH_W  channel for the request; sampled with start_i.
- ADC_value_i  in  ADC_BITWIDTH  measured value; sampled with start_i.
- SET_value_i  in  ADC_BITWIDTH  setpoint; sampled with start_i.
- a1_reg_i, a0_reg_i, b0_reg_i, b1_reg_i, b2_reg_i  in  REG_BITWIDTH each  signed coefficients, shared by all channels, sampled with start_i.
- lim_hi_i, lim_lo_i  in  ADC_BITWIDTH+1 each  signed output clamp limits; lim_lo_i ≤ lim_hi_i is required.
- clr_i  in  1  synchronous clear of all channel history.
- busy_o  out  1  high from the accept cycle until done.
- done_o  out  1  one-cycle pulse when the result is valid.
- ch_o  out  CH_W  channel of the current result.
- out_Val_o  out  ADC_BITWIDTH+1  signed controller output.
- sat_o  out  1  result was clamped.

Behaviour:
- Result width: R = ADC_BITWIDTH + 2*FRAC_BITWIDTH + 5, signed.
- Per-channel state: e1, e2, y1, y2, each R bits.
- Reset: all state 0; busy_o=0, done_o=0, ch_o=0, out_Val_o=0, sat_o=0; FSM=IDLE.
- Error: e = (SET − ADC) << FRAC, sign-extended to R.
- FSM IDLE: on start_i (and clr_i=0) latch ch, e, coefficients and limits; go to MAC0; busy_o=1.
- FSM MAC0..MAC4: one product per cycle, accumulated in an R-bit register, in this order:
  - MAC0: b2·e
  - MAC1: b1·e1
  - MAC2: b0·e2
  - MAC3: −a1·(y1>>>FRAC)
  - MAC4: −a0·(y2>>>FRAC)
- Shifts are arithmetic right shifts (floor).
- FSM SAT: HI = lim_hi<<2F, LO = lim_lo<<2F.
  - acc ≥ HI → y = HI, sat=1; acc ≤ LO → y = LO, sat=1; otherwise y = acc, sat=0.
  - Update the channel state: e2←e1, e1←e, y2←y1, y1←y.
- FSM DONE: done_o=1 for one cycle; out_Val_o = y>>>2F (arithmetic); sat_o and ch_o set; busy_o falls; return to IDLE.
- Latency: start accepted in cycle 0, done_o asserted in cycle 7. Earliest next accept is the cycle after done.
- out_Val_o, sat_o and ch_o hold their values until the next done_o.
- start_i while busy: ignored, not queued.
- ch_i ≥ CH_COUNT: request ignored, stays IDLE, no done_o.
- clr_i: zeroes all channel state the next cycle.
  - Busy: aborts to IDLE, no done_o, outputs unchanged.
  - clr_i with start_i in IDLE: clear wins, start is dropped.
- Other channels' state is never touched by a request.

Decomposition:
- Package pid_pkg: R width function, FSM state encoding, MAC step enumeration, saturation helper function.
- One sub-module, pid_state_ram: CH_COUNT×4 R-bit register file with one read port and a 4-word write-on-SAT port.
- Multiplier/accumulator and FSM stay in the top module.

Test Plan (defaults, lim_hi=255, lim_lo=−256 unless stated):
- P-only: b2=16, others 0, ch0, SET=100, ADC=90 → done at cycle 7, out=10, sat=0, ch_o=0.
- Saturation: b2=127, SET=255, ADC=0 → out=255, sat=1. SET=0, ADC=255 → out=−256, sat=1. lim_hi=50 with the positive case → out=50, sat=1.
- Integrator: a1=−16, b2=16, SET−ADC=1, three requests on ch1 → out 1, 2, 3. ch0 request afterwards with zero error → out=0 (isolation).
- Handshake: start_i during busy → ignored, single done. ch_i=CH_COUNT → no busy, no done.
- Clear: clr_i at cycle 3 of a request → no done_o, history zero; repeating the integrator test → out 1, 2, 3.
- Async reset mid-MAC → all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared types and helpers for the multi-channel PID core: FSM encoding,
// MAC step selection and the output clamp.
package pid_pkg;

  localparam int SAT_W = 64;

  // word positions inside one channel's history entry
  localparam int W_E1 = 0;
  localparam int W_E2 = 1;
  localparam int W_Y1 = 2;
  localparam int W_Y2 = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_MAC0, ST_MAC1, ST_MAC2, ST_MAC3, ST_MAC4, ST_SAT, ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    STEP_B2E, STEP_B1E1, STEP_B0E2, STEP_A1Y1, STEP_A0Y2, STEP_NONE
  } mac_step_t;

  typedef struct packed {
    logic signed [SAT_W-1:0] y;
    logic                    sat;
  } sat_res_t;

  function automatic int r_width(input int adc_w, input int frac_w);
    return adc_w + 2*frac_w + 5;
  endfunction

  function automatic mac_step_t mac_step(input state_t s);
    case (s)
      ST_MAC0: return STEP_B2E;
      ST_MAC1: return STEP_B1E1;
      ST_MAC2: return STEP_B0E2;
      ST_MAC3: return STEP_A1Y1;
      ST_MAC4: return STEP_A0Y2;
      default: return STEP_NONE;
    endcase
  endfunction

  // upper limit is checked first, so a degenerate lo==hi window reports hi
  function automatic sat_res_t saturate(input logic signed [SAT_W-1:0] acc,
                                        input logic signed [SAT_W-1:0] hi,
                                        input logic signed [SAT_W-1:0] lo);
    sat_res_t r;
    r.y   = acc;
    r.sat = 1'b0;
    if (acc >= hi) begin
      r.y   = hi;
      r.sat = 1'b1;
    end else if (acc <= lo) begin
      r.y   = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pid_state_ram.sv
// Per-channel IIR history (e1, e2, y1, y2): one whole-entry read port and
// one whole-entry write port; a clear wipes every channel.
module pid_state_ram import pid_pkg::*; #(
  parameter int CH_COUNT = 2,
  parameter int R        = 21,
  parameter int CH_W     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      addr,
  input  logic [3:0][R-1:0]    wdata,
  output logic [3:0][R-1:0]    rdata
);

  logic [3:0][R-1:0] mem [CH_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH_COUNT; c++) mem[c] <= '0;
    end else begin
      for (int c = 0; c < CH_COUNT; c++) begin
        if (clr)                               mem[c] <= '0;
        else if (wr_en && (32'(addr) == c))    mem[c] <= wdata;
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pid_core_mc.sv
// Time-multiplexed fixed-point PID (2nd-order IIR) for CH_COUNT channels:
// one multiplier, five MAC steps, clamp, then a one-cycle done pulse.
module pid_core_mc import pid_pkg::*; #(
  parameter int ADC_BITWIDTH  = 8,
  parameter int REG_BITWIDTH  = 8,
  parameter int FRAC_BITWIDTH = 4,
  parameter int CH_COUNT      = 2,
  localparam int CH_W = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [CH_W-1:0]         ch_i,
  input  logic [ADC_BITWIDTH-1:0] ADC_value_i,
  input  logic [ADC_BITWIDTH-1:0] SET_value_i,
  input  logic [REG_BITWIDTH-1:0] a1_reg_i,
  input  logic [REG_BITWIDTH-1:0] a0_reg_i,
  input  logic [REG_BITWIDTH-1:0] b0_reg_i,
  input  logic [REG_BITWIDTH-1:0] b1_reg_i,
  input  logic [REG_BITWIDTH-1:0] b2_reg_i,
  input  logic [ADC_BITWIDTH:0]   lim_hi_i,
  input  logic [ADC_BITWIDTH:0]   lim_lo_i,
  input  logic                    clr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CH_W-1:0]         ch_o,
  output logic [ADC_BITWIDTH:0]   out_Val_o,
  output logic                    sat_o
);

  localparam int R  = r_width(ADC_BITWIDTH, FRAC_BITWIDTH);
  localparam int LW = ADC_BITWIDTH + 1;
  localparam int F  = FRAC_BITWIDTH;

  state_t state, nxt;
  logic   accept, ch_ok;

  logic [CH_W-1:0]                ch_q;
  logic signed [R-1:0]            e_q, acc, hi_q, lo_q;
  logic signed [REG_BITWIDTH-1:0] a1_q, a0_q, b0_q, b1_q, b2_q;

  logic signed [LW-1:0] diff;
  logic signed [R-1:0]  e_new;
  logic [3:0][R-1:0]    hist, wdata;

  assign ch_ok = 32'(ch_i) < CH_COUNT;
  assign diff  = $signed({1'b0, SET_value_i}) - $signed({1'b0, ADC_value_i});
  assign e_new = R'(diff) <<< F;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    if (clr_i) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start_i && ch_ok) begin
          nxt    = ST_MAC0;
          accept = 1'b1;
        end
        ST_MAC0: nxt = ST_MAC1;
        ST_MAC1: nxt = ST_MAC2;
        ST_MAC2: nxt = ST_MAC3;
        ST_MAC3: nxt = ST_MAC4;
        ST_MAC4: nxt = ST_SAT;
        ST_SAT:  nxt = ST_DONE;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE) && (state != ST_DONE);
  assign done_o = (state == ST_DONE);

  // ---------------- operand select / MAC ----------------
  mac_step_t                      step;
  logic signed [R-1:0]            opnd, term;
  logic signed [REG_BITWIDTH-1:0] coef;
  logic                           neg;
  logic signed [R+REG_BITWIDTH-1:0] prod;

  assign step = mac_step(state);

  always_comb begin
    opnd = '0;
    coef = '0;
    neg  = 1'b0;
    case (step)
      STEP_B2E:  begin opnd = e_q;                        coef = b2_q; end
      STEP_B1E1: begin opnd = $signed(hist[W_E1]);        coef = b1_q; end
      STEP_B0E2: begin opnd = $signed(hist[W_E2]);        coef = b0_q; end
      STEP_A1Y1: begin opnd = $signed(hist[W_Y1]) >>> F;  coef = a1_q; neg = 1'b1; end
      STEP_A0Y2: begin opnd = $signed(hist[W_Y2]) >>> F;  coef = a0_q; neg = 1'b1; end
      default: ;
    endcase
  end

  // accumulation is modulo 2^R, so negating the truncated product is exact
  assign prod = opnd * coef;
  assign term = neg ? -$signed(prod[R-1:0]) : $signed(prod[R-1:0]);

  // ---------------- clamp / history update ----------------
  sat_res_t            sres;
  logic signed [R-1:0] y_new, y_scaled;
  logic                wr_en;

  assign sres     = saturate(SAT_W'(acc), SAT_W'(hi_q), SAT_W'(lo_q));
  assign y_new    = sres.y[R-1:0];
  assign y_scaled = y_new >>> (2*F);
  assign wr_en    = (state == ST_SAT) && !clr_i;

  always_comb begin
    wdata       = '0;
    wdata[W_E1] = e_q;
    wdata[W_E2] = hist[W_E1];
    wdata[W_Y1] = y_new;
    wdata[W_Y2] = hist[W_Y1];
  end

  pid_state_ram #(.CH_COUNT(CH_COUNT), .R(R), .CH_W(CH_W)) u_ram (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (clr_i),
    .wr_en (wr_en),
    .addr  (ch_q),
    .wdata (wdata),
    .rdata (hist)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_q <= '0; e_q <= '0; acc <= '0; hi_q <= '0; lo_q <= '0;
      a1_q <= '0; a0_q <= '0; b0_q <= '0; b1_q <= '0; b2_q <= '0;
      ch_o <= '0; out_Val_o <= '0; sat_o <= 1'b0;
    end else begin
      if (accept) begin
        ch_q <= ch_i;
        e_q  <= e_new;
        a1_q <= a1_reg_i; a0_q <= a0_reg_i;
        b0_q <= b0_reg_i; b1_q <= b1_reg_i; b2_q <= b2_reg_i;
        hi_q <= R'($signed(lim_hi_i)) <<< (2*F);
        lo_q <= R'($signed(lim_lo_i)) <<< (2*F);
        acc  <= '0;
      end else if (step != STEP_NONE) begin
        acc <= acc + term;
      end
      if (wr_en) begin
        out_Val_o <= y_scaled[LW-1:0];
        sat_o     <= sres.sat;
        ch_o      <= ch_q;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{prod[R+REG_BITWIDTH-1:R], sres.y[SAT_W-1:R], y_scaled[R-1:LW]};

endmodule

// File: tb/tb_pid_core_mc.sv
// Randomized + directed bench for pid_core_mc against a plain-arithmetic
// reference of the per-channel IIR and its request/done timing.
module tb_pid_core_mc;

  localparam int AW = 8, RW = 8, FW = 4, NCH = 3, CW = 2;
  localparam int R  = AW + 2*FW + 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, clr = 1'b0;
  logic [CW-1:0] ch = '0;
  logic [AW-1:0] adc = '0, set = '0;
  logic [RW-1:0] a1 = '0, a0 = '0, b0 = '0, b1 = '0, b2 = '0;
  logic [AW:0]   lim_hi = 9'd255, lim_lo = 9'h100;
  logic          busy, done, sat;
  logic [CW-1:0] ch_out;
  logic [AW:0]   out_val;

  always #5 clk = ~clk;

  pid_core_mc #(.ADC_BITWIDTH(AW), .REG_BITWIDTH(RW), .FRAC_BITWIDTH(FW), .CH_COUNT(NCH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ch_i(ch),
    .ADC_value_i(adc), .SET_value_i(set),
    .a1_reg_i(a1), .a0_reg_i(a0), .b0_reg_i(b0), .b1_reg_i(b1), .b2_reg_i(b2),
    .lim_hi_i(lim_hi), .lim_lo_i(lim_lo), .clr_i(clr),
    .busy_o(busy), .done_o(done), .ch_o(ch_out), .out_Val_o(out_val), .sat_o(sat)
  );

  int nerr = 0, nchk = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint me1[NCH], me2[NCH], my1[NCH], my2[NCH];
  int     phase = 0;
  longint p_out = 0, exp_out = 0;
  int     p_sat = 0, exp_sat = 0, p_ch = 0, exp_ch = 0;

  function automatic longint wrapr(input longint v);
    longint m = v & ((64'sd1 <<< R) - 1);
    if (m >= (64'sd1 <<< (R-1))) m -= (64'sd1 <<< R);
    return m;
  endfunction

  task automatic model_accept();
    int c = int'(ch);
    longint e, acc, hi, lo, y;
    e   = (longint'(set) - longint'(adc)) * 16;
    acc = wrapr(longint'($signed(b2)) * e + longint'($signed(b1)) * me1[c]
              + longint'($signed(b0)) * me2[c]
              - longint'($signed(a1)) * (my1[c] >>> FW)
              - longint'($signed(a0)) * (my2[c] >>> FW));
    hi = longint'($signed(lim_hi)) * 256;
    lo = longint'($signed(lim_lo)) * 256;
    if (acc >= hi)      begin y = hi;  p_sat = 1; end
    else if (acc <= lo) begin y = lo;  p_sat = 1; end
    else                begin y = acc; p_sat = 0; end
    me2[c] = me1[c]; me1[c] = e;
    my2[c] = my1[c]; my1[c] = y;
    p_out = y >>> (2*FW);
    p_ch  = c;
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      me1[c] = 0; me2[c] = 0; my1[c] = 0; my2[c] = 0;
    end
  endtask

  initial model_clear();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
      phase = 0; exp_out = 0; exp_sat = 0; exp_ch = 0;
    end else if (clr) begin
      model_clear();
      phase = 0;
    end else if (phase == 0) begin
      if (start && int'(ch) < NCH) begin
        model_accept();
        phase = 1;
      end
    end else if (phase == 7) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == 7) begin
        exp_out = p_out; exp_sat = p_sat; exp_ch = p_ch;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", longint'(done), longint'(phase == 7));
      chk("busy", longint'(busy), longint'(phase >= 1 && phase <= 6));
      chk("out",  longint'($signed(out_val)), exp_out);
      chk("sat",  longint'(sat), longint'(exp_sat));
      chk("ch",   longint'(ch_out), longint'(exp_ch));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic req(input int c, input int sp, input int ad, input int ka1, input int kb2,
                     input int hi, input int lo,
                     output int lat, output longint o, output int s, output int oc);
    @(posedge clk); #1;
    ch = CW'(c); set = AW'(sp); adc = AW'(ad);
    a1 = RW'(ka1); a0 = '0; b0 = '0; b1 = '0; b2 = RW'(kb2);
    lim_hi = 9'(hi); lim_lo = 9'(lo);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; o = 0; s = 0; oc = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (done) begin
        o = longint'($signed(out_val)); s = int'(sat); oc = int'(ch_out);
        break;
      end
      lat++;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic count_events(input int cycles, output int nd, output int nb);
    nd = 0; nb = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, s, oc, nd, nb;
    longint o;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out",  longint'($signed(out_val)), 0);
    chk("rst_sat",  sat, 0);
    chk("rst_ch",   ch_out, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    req(0, 100, 90, 0, 16, 255, -256, lat, o, s, oc);
    chk("p_lat", lat, 7); chk("p_out", o, 10); chk("p_sat", s, 0); chk("p_ch", oc, 0);

    req(2, 255, 0, 0, 127, 255, -256, lat, o, s, oc);
    chk("satp_out", o, 255); chk("satp_sat", s, 1); chk("satp_ch", oc, 2);
    req(2, 0, 255, 0, 127, 255, -256, lat, o, s, oc);
    chk("satn_out", o, -256); chk("satn_sat", s, 1);
    req(1, 255, 0, 0, 127, 50, -256, lat, o, s, oc);
    chk("lim50_out", o, 50); chk("lim50_sat", s, 1);

    pulse_clr();
    for (int k = 1; k <= 3; k++) begin
      req(1, 101, 100, -16, 16, 255, -256, lat, o, s, oc);
      chk("integ_out", o, k);
    end
    req(0, 50, 50, -16, 16, 255, -256, lat, o, s, oc);
    chk("iso_out", o, 0); chk("iso_ch", oc, 0);

    // start while busy is dropped
    @(posedge clk); #1;
    ch = 2'd0; set = 8'd10; adc = 8'd0; b2 = 8'd16; a1 = '0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; ch = 2'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    count_events(25, nd, nb);
    chk("busy_start_dones", nd, 1);

    // out-of-range channel
    @(posedge clk); #1; ch = 2'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    count_events(10, nd, nb);
    chk("badch_done", nd, 0); chk("badch_busy", nb, 0);

    // clear mid-request aborts and wipes history
    @(posedge clk); #1;
    ch = 2'd1; set = 8'd101; adc = 8'd100; a1 = 8'hF0; b2 = 8'd16; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    count_events(15, nd, nb);
    chk("clr_done", nd, 0);
    for (int k = 1; k <= 3; k++) begin
      req(1, 101, 100, -16, 16, 255, -256, lat, o, s, oc);
      chk("clr_integ_out", o, k);
    end

    // async reset mid-MAC
    @(posedge clk); #1;
    ch = 2'd2; set = 8'd200; adc = 8'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_out",  longint'($signed(out_val)), 0);
    chk("arst_ch",   ch_out, 0);
    @(posedge clk); #1; rst = 1'b0;
    req(0, 100, 90, 0, 16, 255, -256, lat, o, s, oc);
    chk("post_rst_lat", lat, 7); chk("post_rst_out", o, 10);

    // randomized traffic
    repeat (800) begin
      int x, y;
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      ch    = CW'($urandom_range(0, 3));
      set   = AW'($urandom); adc = AW'($urandom);
      a1 = RW'($urandom); a0 = RW'($urandom); b0 = RW'($urandom);
      b1 = RW'($urandom); b2 = RW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        lim_hi = 9'd255; lim_lo = 9'h100;
      end else begin
        x = int'($urandom_range(0, 511)) - 256;
        y = int'($urandom_range(0, 511)) - 256;
        lim_hi = 9'((x > y) ? x : y);
        lim_lo = 9'((x > y) ? y : x);
      end
    end
    @(posedge clk); #1; start = 1'b0; clr = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
